// File: rtl/fetch_unit.sv
// Fetch stage: owns the program counter that addresses the instruction ROM
// and registers the returned word for the decoder. Sequences start/halt,
// honours stall, flushes the wrong-path fetch on a taken branch, and counts
// the cycles spent running.
module fetch_unit #(
    parameter int unsigned D       = 12,
    parameter logic [8:0]  HALT_OP = 9'b111111111,
    parameter int unsigned CW      = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Stall,
    input  logic          Branch,
    input  logic [D-1:0]  Target,
    input  logic [8:0]    InstIn,
    output logic [D-1:0]  PrgCtr,
    output logic [8:0]    InstOut,
    output logic          InstValid,
    output logic          Done,
    output logic [CW-1:0] CycleCt
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [8:0]    inst_q, inst_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [CW-1:0] cyc_q, cyc_d;

    // State and datapath registers; reset aborts everything at once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state logic; everything holds unless a case below says otherwise.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        done_d  = done_q;
        cyc_d   = cyc_q;

        unique case (state_q)
            StIdle, StHalt: begin
                if (Start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                    cyc_d   = '0;
                end
            end
            StRun: begin
                if (Start) begin
                    // Restart: the counter restarts from zero rather than counting this edge.
                    pc_d    = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                    if (Stall) begin
                        // Freeze fetch; a simultaneous branch is dropped.
                    end else if (Branch) begin
                        // Word at the current PC is wrong-path: drop it, keep old InstOut.
                        pc_d    = Target;
                        valid_d = 1'b0;
                    end else if (InstIn == HALT_OP) begin
                        state_d = StHalt;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        inst_d  = InstIn;
                        valid_d = 1'b1;
                        pc_d    = pc_q + D'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign PrgCtr    = pc_q;
    assign InstOut   = inst_q;
    assign InstValid = valid_q;
    assign Done      = done_q;
    assign CycleCt   = cyc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural ROM, per-cycle vector table with
// expected outputs queued as stimulus is driven and checked after each edge.
module tb_fetch_unit;

    localparam int unsigned D  = 12;
    localparam int unsigned CW = 16;
    localparam logic [8:0]  HALT = 9'h1FF;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Start, Stall, Branch;
    logic [D-1:0]  Target;
    logic [8:0]    InstIn;
    logic [D-1:0]  PrgCtr;
    logic [8:0]    InstOut;
    logic          InstValid, Done;
    logic [CW-1:0] CycleCt;

    logic [8:0] rom [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          start, stall, branch;
        logic [D-1:0]  target;
        logic [D-1:0]  pc;
        logic [8:0]    inst;
        logic          valid, done;
        logic [CW-1:0] cyc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    fetch_unit #(.D(D), .HALT_OP(HALT), .CW(CW)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Stall     (Stall),
        .Branch    (Branch),
        .Target    (Target),
        .InstIn    (InstIn),
        .PrgCtr    (PrgCtr),
        .InstOut   (InstOut),
        .InstValid (InstValid),
        .Done      (Done),
        .CycleCt   (CycleCt)
    );

    always #5 Clk = ~Clk;

    // Combinational ROM.
    assign InstIn = rom[PrgCtr];

    // Default ROM image; never produces HALT (max value 510).
    function automatic logic [8:0] f(input int a);
        return 9'((a * 37 + 5) % 511);
    endfunction

    function automatic vec_t v(input logic st, input logic sl, input logic br,
                               input int tg, input int pc, input logic [8:0] inst,
                               input logic vl, input logic dn, input int cyc);
        vec_t r;
        r.start = st; r.stall = sl; r.branch = br; r.target = D'(tg);
        r.pc = D'(pc); r.inst = inst; r.valid = vl; r.done = dn; r.cyc = CW'(cyc);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".PrgCtr"},    32'(PrgCtr),    32'(e.pc));
        chk({tag, ".InstOut"},   32'(InstOut),   32'(e.inst));
        chk({tag, ".InstValid"}, 32'(InstValid), 32'(e.valid));
        chk({tag, ".Done"},      32'(Done),      32'(e.done));
        chk({tag, ".CycleCt"},   32'(CycleCt),   32'(e.cyc));
    endtask

    task automatic run(input int lo, input int hi);
        vec_t e;
        for (int i = lo; i <= hi; i++) begin
            @(negedge Clk);
            Start  = tbl[i].start;
            Stall  = tbl[i].stall;
            Branch = tbl[i].branch;
            Target = tbl[i].target;
            sb.push_back(tbl[i]);
            @(posedge Clk);
            #1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                chk_all($sformatf("vec%0d", i), e);
            end
        end
        @(negedge Clk);
        Start = 1'b0; Stall = 1'b0; Branch = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t z;
        // Segment A (0..6): run to HALT.
        tbl.push_back(v(1,0,0,0, 0, 9'h000, 0,0,0));
        tbl.push_back(v(0,0,0,0, 1, 9'h03C, 1,0,1));
        tbl.push_back(v(0,0,0,0, 2, 9'h0CC, 1,0,2));
        tbl.push_back(v(0,0,0,0, 3, 9'h07A, 1,0,3));
        tbl.push_back(v(0,0,0,0, 3, 9'h07A, 0,1,4));
        tbl.push_back(v(0,1,1,9, 3, 9'h07A, 0,1,4));
        tbl.push_back(v(0,0,0,0, 3, 9'h07A, 0,1,4));
        // Segment B (7..28): restart from HALT, branch, stall, wrap.
        tbl.push_back(v(1,0,0,0,     'h000, 9'h07A,   0,0,0));
        tbl.push_back(v(0,0,0,0,     'h001, f(0),     1,0,1));
        tbl.push_back(v(0,0,0,0,     'h002, f(1),     1,0,2));
        tbl.push_back(v(0,0,0,0,     'h003, f(2),     1,0,3));
        tbl.push_back(v(0,0,0,0,     'h004, f(3),     1,0,4));
        tbl.push_back(v(0,0,0,0,     'h005, f(4),     1,0,5));
        tbl.push_back(v(0,0,1,'h100, 'h100, f(4),     0,0,6));
        tbl.push_back(v(0,0,0,0,     'h101, f('h100), 1,0,7));
        tbl.push_back(v(0,0,0,0,     'h102, f('h101), 1,0,8));
        tbl.push_back(v(0,0,1,'h005, 'h005, f('h101), 0,0,9));
        tbl.push_back(v(0,0,0,0,     'h006, f(5),     1,0,10));
        tbl.push_back(v(0,0,0,0,     'h007, f(6),     1,0,11));
        tbl.push_back(v(0,1,1,'h200, 'h007, f(6),     1,0,12));
        tbl.push_back(v(0,1,1,'h200, 'h007, f(6),     1,0,13));
        tbl.push_back(v(0,1,1,'h200, 'h007, f(6),     1,0,14));
        tbl.push_back(v(0,0,0,0,     'h008, f(7),     1,0,15));
        tbl.push_back(v(0,0,1,'h300, 'h300, f(7),     0,0,16));
        tbl.push_back(v(0,0,0,0,     'h301, f('h300), 1,0,17));
        tbl.push_back(v(0,0,1,'hFFF, 'hFFF, f('h300), 0,0,18));
        tbl.push_back(v(0,0,0,0,     'h000, f('hFFF), 1,0,19));
        tbl.push_back(v(0,0,0,0,     'h001, f(0),     1,0,20));
        tbl.push_back(v(0,0,1,'h020, 'h020, f(0),     0,0,21));
        // Segment C (29..31): after async reset, IDLE holds, then a restart.
        tbl.push_back(v(0,1,1,'h055, 0, 9'h000, 0,0,0));
        tbl.push_back(v(1,0,0,0,     0, 9'h000, 0,0,0));
        tbl.push_back(v(0,0,0,0,     1, f(0),   1,0,1));

        for (int a = 0; a < 4096; a++) rom[a] = f(a);
        rom[0] = 9'h03C; rom[1] = 9'h0CC; rom[2] = 9'h07A; rom[3] = HALT;

        Start = 1'b0; Stall = 1'b0; Branch = 1'b0; Target = '0;
        Reset_n = 1'b0;
        #1;
        z = v(0,0,0,0, 0, 9'h000, 0,0,0);
        chk_all("reset", z);
        @(negedge Clk);
        Reset_n = 1'b1;

        run(0, 6);

        // New image for B: HALT at 8 is reached only with a branch pending.
        for (int a = 0; a < 4096; a++) rom[a] = f(a);
        rom[8] = HALT;
        run(7, 28);

        // Async reset mid-RUN at PrgCtr=20h, away from any clock edge.
        #2;
        Reset_n = 1'b0;
        #1;
        chk_all("async_reset", z);
        @(posedge Clk);
        #1;
        chk_all("reset_held", z);
        @(negedge Clk);
        Reset_n = 1'b1;
        run(29, 31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
